// File: rtl/matrix_encode_ctrl.sv
// Line-by-line 5x5 bit-permutation engine: read a 25-bit line, apply pi ROUNDS times, write it back.
// Optional feature macro: WR_PARITY_EN adds the wr_parity output (XOR of wr_data).
module matrix_encode_ctrl #(
    parameter int LINES  = 64,
    parameter int ADDR_W = 6,
    parameter int ROUNDS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [24:0]       rd_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [24:0]       wr_data,
    input  logic              wr_ready
`ifdef WR_PARITY_EN
    ,
    output logic              wr_parity
`endif
);

    localparam int                DATA_W   = 25;
    localparam logic [ADDR_W-1:0] LAST_LN  = ADDR_W'(LINES - 1);
    localparam logic [4:0]        LAST_RND = 5'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        PERM = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   line_cnt;
    logic [4:0]          rnd_cnt;
    logic [DATA_W-1:0]   work;

    // Bit 5y+x of the lane grid moves to 5*((2x+3y) mod 5) + y.
    function automatic logic [DATA_W-1:0] pi_perm(input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] r;
        int                d;
        r = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                d = 5 * ((2 * x + 3 * y) % 5) + y;
                r[5'(d)] = a[5'(5 * y + x)];
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RD;
            RD:      if (rd_ack) state_nx = PERM;
            PERM:    if (rnd_cnt == LAST_RND) state_nx = WR;
            WR:      if (wr_ready) state_nx = (line_cnt == LAST_LN) ? DONE : RD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counters and work register; all cleared by reset so an abandoned job leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt <= '0;
            rnd_cnt  <= '0;
            work     <= '0;
        end else begin
            case (state)
                IDLE: if (start) line_cnt <= '0;
                RD: begin
                    if (rd_ack) begin
                        work    <= rd_data;
                        rnd_cnt <= '0;
                    end
                end
                PERM: begin
                    work    <= pi_perm(work);
                    rnd_cnt <= rnd_cnt + 5'd1;
                end
                WR: if (wr_ready && line_cnt != LAST_LN) line_cnt <= line_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Addresses and data are gated by their request so every output is 0 outside a handshake.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        case (state)
            IDLE: ;
            RD: begin
                busy    = 1'b1;
                rd_req  = 1'b1;
                rd_addr = line_cnt;
            end
            PERM: busy = 1'b1;
            WR: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                wr_addr  = line_cnt;
                wr_data  = work;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef WR_PARITY_EN
    assign wr_parity = ^wr_data;
`endif

endmodule

// File: tb/tb_matrix_encode_ctrl.sv
// Directed bench for matrix_encode_ctrl: a LINES=4/ROUNDS=1 instance and a LINES=1/ROUNDS=24 instance.
module tb_matrix_encode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, rd_ack, wr_ready;
    logic [24:0] rd_data;
    logic        busy, done, rd_req, wr_valid;
    logic [5:0]  rd_addr, wr_addr;
    logic [24:0] wr_data;
`ifdef WR_PARITY_EN
    logic        wr_parity, wr_parity_b;
`endif

    logic        start_b, rd_ack_b, wr_ready_b;
    logic [24:0] rd_data_b;
    logic        busy_b, done_b, rd_req_b, wr_valid_b;
    logic [5:0]  rd_addr_b, wr_addr_b;
    logic [24:0] wr_data_b;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    matrix_encode_ctrl #(.LINES(4), .ADDR_W(6), .ROUNDS(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
`ifdef WR_PARITY_EN
        , .wr_parity(wr_parity)
`endif
    );

    matrix_encode_ctrl #(.LINES(1), .ADDR_W(6), .ROUNDS(24)) u_dut24 (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_ack(rd_ack_b), .rd_data(rd_data_b),
        .wr_valid(wr_valid_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b)
`ifdef WR_PARITY_EN
        , .wr_parity(wr_parity_b)
`endif
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rd_req && wr_valid) overlap++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Zero-wait line: expects the DUT in RD for line k; leaves it in the following state.
    task automatic do_line(input int k, input logic [24:0] din, input logic [24:0] dexp);
        chk("zw_rd_req", 32'(rd_req), 32'd1);
        chk("zw_rd_addr", 32'(rd_addr), 32'(k));
        rd_ack = 1'b1; rd_data = din;
        step();
        rd_ack = 1'b0; rd_data = '0;
        chk("zw_perm_wr_valid", 32'(wr_valid), 32'd0);
        step();
        chk("zw_wr_valid", 32'(wr_valid), 32'd1);
        chk("zw_wr_addr", 32'(wr_addr), 32'(k));
        chk("zw_wr_data", 32'(wr_data), 32'(dexp));
`ifdef WR_PARITY_EN
        chk("zw_wr_parity", 32'(wr_parity), 32'(^dexp));
`endif
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
    endtask

    logic [24:0] din  [4];
    logic [24:0] dexp [4];

    initial begin
        int n;
        int d0;
        din[0] = 25'h0000002; dexp[0] = 25'h0000400;
        din[1] = 25'h0000007; dexp[1] = 25'h0100401;
        din[2] = 25'h1000000; dexp[2] = 25'h0000010;
        din[3] = 25'h0000003; dexp[3] = 25'h0000401;

        rst = 1'b1; start = 1'b0; rd_ack = 1'b0; wr_ready = 1'b0; rd_data = '0;
        start_b = 1'b0; rd_ack_b = 1'b0; wr_ready_b = 1'b0; rd_data_b = '0;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Job 1: start held high, delayed read and write handshakes.
        d0 = done_cnt;
        start = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rd_req && n < 20) begin step(); n++; end
            chk("wait_rd_req", 32'(rd_req), 32'd1);
            chk("rd_addr", 32'(rd_addr), 32'(k));
            for (int w = 0; w < 3; w++) begin
                step();
                chk("rd_hold_req", 32'(rd_req), 32'd1);
                chk("rd_hold_addr", 32'(rd_addr), 32'(k));
                chk("rd_hold_no_wr", 32'(wr_valid), 32'd0);
            end
            rd_ack = 1'b1; rd_data = din[k];
            step();
            rd_ack = 1'b0; rd_data = '0;
            chk("perm_busy", 32'(busy), 32'd1);
            step();
            chk("wr_valid", 32'(wr_valid), 32'd1);
            chk("wr_addr", 32'(wr_addr), 32'(k));
            chk("wr_data", 32'(wr_data), 32'(dexp[k]));
`ifdef WR_PARITY_EN
            chk("wr_parity", 32'(wr_parity), 32'(^dexp[k]));
`endif
            for (int w = 0; w < 2; w++) begin
                step();
                chk("wr_hold_valid", 32'(wr_valid), 32'd1);
                chk("wr_hold_addr", 32'(wr_addr), 32'(k));
                chk("wr_hold_data", 32'(wr_data), 32'(dexp[k]));
                chk("wr_hold_no_rd", 32'(rd_req), 32'd0);
            end
            wr_ready = 1'b1;
            step();
            wr_ready = 1'b0;
        end
        chk("job1_done", 32'(done), 32'd1);
        chk("job1_done_busy", 32'(busy), 32'd1);
        step();
        chk("after_done_pulse", 32'(done), 32'd0);
        chk("after_done_busy", 32'(busy), 32'd0);
        step();
        chk("retrigger_rd_req", 32'(rd_req), 32'd1);
        chk("retrigger_rd_addr", 32'(rd_addr), 32'd0);
        chk("job1_done_pulses", 32'(done_cnt - d0), 32'd1);
        start = 1'b0;

        // Job 2: abandoned by reset during WR of line 2 with wr_ready low.
        do_line(0, din[0], dexp[0]);
        do_line(1, din[1], dexp[1]);
        rd_ack = 1'b1; rd_data = din[2];
        step();
        rd_ack = 1'b0; rd_data = '0;
        step();
        chk("abort_wr_valid", 32'(wr_valid), 32'd1);
        chk("abort_wr_addr", 32'(wr_addr), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_req", 32'(rd_req), 32'd0);
        chk("abort_wr_valid0", 32'(wr_valid), 32'd0);
        chk("abort_rd_addr", 32'(rd_addr), 32'd0);
        chk("abort_wr_addr0", 32'(wr_addr), 32'd0);
        chk("abort_wr_data", 32'(wr_data), 32'd0);
        step();
        chk("abort_idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;

        // Job 3: zero-wait handshakes, done exactly 3 cycles after the last RD cycle.
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) do_line(k, din[k], dexp[k]);
        chk("job3_done", 32'(done), 32'd1);
        step();
        chk("job3_idle_busy", 32'(busy), 32'd0);
        chk("job3_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("rd_wr_overlap", 32'(overlap), 32'd0);

        // ROUNDS=24 instance: pi has order 24, so the line comes back unchanged.
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("b_rd_req", 32'(rd_req_b), 32'd1);
        rd_ack_b = 1'b1; rd_data_b = 25'h1ABCDEF;
        step();
        rd_ack_b = 1'b0; rd_data_b = '0;
        n = 0;
        while (!wr_valid_b && n < 40) begin step(); n++; end
        chk("b_perm_cycles", 32'(n), 32'd24);
        chk("b_wr_data", 32'(wr_data_b), 32'h1ABCDEF);
        chk("b_wr_addr", 32'(wr_addr_b), 32'd0);
        wr_ready_b = 1'b1;
        step();
        wr_ready_b = 1'b0;
        chk("b_done", 32'(done_b), 32'd1);
        step();
        chk("b_idle_busy", 32'(busy_b), 32'd0);
        chk("b_idle_done", 32'(done_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
